// File: rtl/rr_index_arbiter_pkg.sv
// rtl/rr_index_arbiter_pkg.sv - shared parameters and state type for the round-robin index arbiter
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    OWNED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_index_arbiter_if.sv
// rtl/rr_index_arbiter_if.sv - request/offer/ownership bundle between arbiter and consumer
interface rr_index_arbiter_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_ready;
  logic             busy;
  logic             done;

  // Arbiter side: samples requests and the consumer handshake, drives the grant.
  modport master (
    input  req,
    input  gnt_ready,
    input  done,
    output gnt_valid,
    output gnt_idx,
    output busy
  );

  // Consumer side: raises requests, accepts offers, ends ownership.
  modport slave (
    output req,
    output gnt_ready,
    output done,
    input  gnt_valid,
    input  gnt_idx,
    input  busy
  );

endinterface

// File: rtl/rr_index_arbiter_rr_pick.sv
// rtl/rr_index_arbiter_rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   enc;

  // Rotate so ptr lands at bit 0, find the lowest set bit, then undo the rotation.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    enc = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc = i[IDX_W-1:0];
      end
    end
    any = |req;
    idx = enc + ptr;
  end

endmodule

// File: rtl/rr_index_arbiter.sv
// rtl/rr_index_arbiter.sv - round-robin arbiter producing a registered grant index with offer/own phases
module rr_index_arbiter
  import arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  rr_index_arbiter_if.master   bus
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             busy_q, busy_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  rr_pick u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state logic; outputs are computed here and registered so nothing
  // combinational reaches the ports.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        // Offer is never withdrawn; only the handshake moves it on.
        if (gnt_valid_q && bus.gnt_ready) begin
          gnt_valid_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = OWNED;
        end
      end
      OWNED: begin
        // Pointer advances past the owner so it gets lowest priority next round.
        if (bus.done) begin
          busy_d  = 1'b0;
          ptr_d   = gnt_idx_q + 3'd1;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// tb/tb_rr_index_arbiter.sv - directed bench for rr_index_arbiter
module tb_rr_index_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  rr_index_arbiter_if bus ();

  rr_index_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Downstream 3-to-8 decoder driven by the grant index.
  logic [7:0] y;
  assign y = 8'b0000_0001 << bus.gnt_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic eb, input logic [2:0] ei);
    logic [7:0] ey;
    ey = 8'b0000_0001 << ei;
    chk({tag, ".gnt_valid"}, int'(bus.gnt_valid), int'(ev));
    chk({tag, ".busy"}, int'(bus.busy), int'(eb));
    chk({tag, ".gnt_idx"}, int'(bus.gnt_idx), int'(ei));
    chk({tag, ".y"}, int'(y), int'(ey));
  endtask

  // From IDLE with requests present: offer, accept, release.
  task automatic grant_cycle(input string tag, input logic [2:0] ei);
    step();
    chk_out({tag, ".offer"}, 1'b1, 1'b0, ei);
    bus.gnt_ready = 1'b1;
    step();
    chk_out({tag, ".own"}, 1'b0, 1'b1, ei);
    bus.gnt_ready = 1'b0;
    bus.done      = 1'b1;
    step();
    chk_out({tag, ".release"}, 1'b0, 1'b0, ei);
    bus.done      = 1'b0;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.req       = 8'h00;
    bus.gnt_ready = 1'b0;
    bus.done      = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_out("reset", 1'b0, 1'b0, 3'd0);

    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("idle_noreq", 1'b0, 1'b0, 3'd0);
    end

    bus.req = 8'b1010_0100;
    grant_cycle("rr_a", 3'd2);
    grant_cycle("rr_b", 3'd5);
    grant_cycle("rr_c", 3'd7);
    grant_cycle("rr_wrap", 3'd2);

    bus.req = 8'b0100_0000;
    grant_cycle("to6", 3'd6);
    bus.req = 8'b0000_0001;
    grant_cycle("wrap0", 3'd0);
    bus.req = 8'b0000_0011;
    grant_cycle("ptr1", 3'd1);

    bus.req = 8'b0001_0000;
    step();
    chk_out("hold.offer", 1'b1, 1'b0, 3'd4);
    bus.req = 8'h00;
    for (int i = 0; i < 4; i++) begin
      bus.done = (i % 2 == 0);
      step();
      chk_out("hold.stall", 1'b1, 1'b0, 3'd4);
    end
    bus.done      = 1'b0;
    bus.gnt_ready = 1'b1;
    step();
    chk_out("hold.own", 1'b0, 1'b1, 3'd4);
    bus.gnt_ready = 1'b0;
    bus.req       = 8'hFF;
    step();
    chk_out("hold.req_ignored", 1'b0, 1'b1, 3'd4);
    bus.req  = 8'h00;
    bus.done = 1'b1;
    step();
    chk_out("hold.release", 1'b0, 1'b0, 3'd4);
    bus.done = 1'b0;

    bus.req = 8'b0010_0000;
    step();
    chk_out("rst.offer", 1'b1, 1'b0, 3'd5);
    bus.gnt_ready = 1'b1;
    step();
    chk_out("rst.own", 1'b0, 1'b1, 3'd5);
    bus.gnt_ready = 1'b0;
    rst      = 1'b1;
    bus.done = 1'b1;
    step();
    chk_out("rst.owned", 1'b0, 1'b0, 3'd0);
    rst      = 1'b0;
    bus.done = 1'b0;
    bus.req  = 8'hFF;
    step();
    chk_out("rst.reoffer", 1'b1, 1'b0, 3'd0);

    bus.gnt_ready = 1'b1;
    step();
    chk_out("b2b.own", 1'b0, 1'b1, 3'd0);
    bus.gnt_ready = 1'b0;
    bus.done      = 1'b1;
    step();
    chk_out("b2b.bubble", 1'b0, 1'b0, 3'd0);
    bus.done = 1'b0;
    step();
    chk_out("b2b.offer", 1'b1, 1'b0, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_index_arbiter.md
# rr_index_arbiter

Round-robin arbiter for eight requesters. Produces a registered 3-bit grant index, not a one-hot vector. Sits directly upstream of the 3-to-8 `decoder`: `gnt_idx` drives the decoder's `D` input, and the decoder's `y` becomes the one-hot grant bus. A valid/ready offer plus an ownership phase ended by `done` make the grant stable for a whole transaction.

## Interface
- `N_REQ`, 8, number of requesters; fixed at 8 to match the decoder width.
- `IDX_W`, 3, index width; equals `$clog2(N_REQ)` and is not overridden.

- `clk`, in, 1, the only clock; all state updates on the rising edge.
- `rst`, in, 1, reset; synchronous, active-high.
- `req`, in, 8, request lines; bit i high means requester i wants ownership.
- `gnt_valid`, out, 1, an offer is pending (state OFFER).
- `gnt_idx`, out, 3, index of the offered or owning requester.
- `gnt_ready`, in, 1, consumer accepts the offer.
- `busy`, out, 1, a grant is owned (state OWNED).
- `done`, in, 1, one-cycle pulse ending ownership.

## Operation
- States: IDLE, OFFER, OWNED. Internal round-robin pointer `ptr[2:0]`.
- IDLE, `req == 0`:
  - Stay in IDLE; outputs unchanged.
- IDLE, `req != 0`:
  - Select the first set bit scanning `ptr, ptr+1, …, 7, 0, …, ptr-1` (mod 8).
  - Register that index into `gnt_idx` and go to OFFER.
- OFFER:
  - `gnt_valid = 1`.
  - `gnt_idx` stays stable until handshake; the offer is not withdrawn if `req` drops.
  - `gnt_valid && gnt_ready` → OWNED.
  - `done` is ignored.
- OWNED:
  - `busy = 1`, `gnt_valid = 0`, `gnt_idx` held.
  - `done` → IDLE and `ptr <= gnt_idx + 1` (3-bit wrap, so 7 → 0).
  - `req` is ignored.
- `done` in IDLE or OFFER: no effect.
- `ptr` changes only on `done` in OWNED, or on reset.
- Reset (any state, including mid-offer or mid-ownership):
  - Next edge gives IDLE, `ptr = 0`, `gnt_valid = 0`, `busy = 0`, `gnt_idx = 0`.
  - Reset has priority over every other input.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Arbitration latency:
  - `req` sampled in IDLE at edge k gives `gnt_valid = 1` after edge k.
  - `gnt_ready` is checked at edge k+1 at the earliest.
- Handshake:
  - Accept at edge m sets `busy = 1` after edge m.
  - `gnt_valid` falls after the same edge.
- Release:
  - `done` at edge n sets `busy = 0` after edge n.
  - Earliest next offer: `gnt_valid` after edge n+1, a one-cycle IDLE bubble by design.
- Minimum grant cycle: 3 clocks (IDLE, OFFER, OWNED), with `gnt_ready` and `done` each held for one cycle.
- `gnt_idx` changes only on the IDLE→OFFER edge or on reset.
- The decoder output is glitch-free between grants.

## Structure
- Package `arb_pkg`:
  - `localparam N_REQ = 8`, `IDX_W = 3`.
  - `typedef enum logic [1:0] {IDLE, OFFER, OWNED} arb_state_t`.
- Sub-module `rr_pick`:
  - Purely combinational.
  - Inputs: `req[7:0]`, `ptr[2:0]`. Outputs: `any`, `idx[2:0]`.
  - Method: rotate `req` right by `ptr`, priority-encode the lowest set bit, add `ptr` back mod 8.
- Top module: state register, `ptr`, `gnt_idx`, and output registers.

## Test plan
- Reset, then `req = 8'b0000_0000` for 5 cycles:
  - Required: `gnt_valid = 0`, `busy = 0`, `gnt_idx = 0` throughout.
- `req = 8'b1010_0100`, `ptr = 0`:
  - Required: `gnt_valid = 1`, `gnt_idx = 2` one cycle later.
  - `gnt_ready = 1` gives `busy = 1`; `done` gives `ptr = 3`.
  - Next offer is `gnt_idx = 5`, then 7, then (after wrap) 2.
- `req = 8'b0000_0001` with `ptr = 7` (after a grant to 6):
  - Required: wrap-around offer `gnt_idx = 0`; after `done`, `ptr = 1`.
- OFFER with `gnt_ready = 0` for 4 cycles while `req` drops to 0:
  - Required: `gnt_valid` stays 1 and `gnt_idx` is unchanged.
  - `done` pulses in OFFER are ignored.
- `rst = 1` asserted while OWNED (`gnt_idx = 5`):
  - Required: next cycle IDLE, `busy = 0`, `gnt_idx = 0`.
  - Subsequent `req = 8'hFF` gives offer `gnt_idx = 0`.
- Same-cycle `done` and new `req` in OWNED:
  - Required: exactly one IDLE cycle, then `gnt_valid = 1`.
  - Drive `gnt_idx` into `decoder`: `y` equals `1 << gnt_idx` and is checked every cycle.
